// File: rtl/decrypt_iter.sv
// Iterative 16-bit nibble-cipher decryptor, one inverse round per clock.
// Optional macro DECRYPT_KEY_LOCK_EN: reject key writes while a block is in flight.
module decrypt_iter #(
   parameter int NUM_ROUNDS = 3,
   parameter int KA_W       = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_message,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     out_message,
   input  logic            key_wr_en,
   input  logic [KA_W-1:0] key_wr_addr,
   input  logic [15:0]     key_wr_data,
   output logic            key_wr_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]      fsm_q, fsm_d;
   logic [15:0]     blk_q, blk_d;
   logic [KA_W-1:0] cnt_q, cnt_d;
   logic [15:0]     key_q [NUM_ROUNDS+1];
   logic            key_we;
   logic            key_in_range;
   logic [15:0]     round_out;

   // GF(2^4) multiply by x, reduction polynomial x^4 + x + 1
   function automatic logic [3:0] xtime(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] mul9(input logic [3:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
         4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
         4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
         4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
      endcase
      return r;
   endfunction

   // Columns are nibble pairs {0,1} and {2,3}; ShiftRow swaps nibbles 1 and 3.
   function automatic logic [15:0] inv_round(input logic [15:0] s, input logic [15:0] k);
      logic [3:0] m0, m1, m2, m3;
      m0 = mul9(s[15:12]) ^ xtime(s[11:8]);
      m1 = xtime(s[15:12]) ^ mul9(s[11:8]);
      m2 = mul9(s[7:4]) ^ xtime(s[3:0]);
      m3 = xtime(s[7:4]) ^ mul9(s[3:0]);
      return {inv_sbox(m0), inv_sbox(m3), inv_sbox(m2), inv_sbox(m1)} ^ k;
   endfunction

   assign round_out    = inv_round(blk_q, key_q[cnt_q]);
   assign key_in_range = ({1'b0, key_wr_addr} <= (KA_W+1)'(NUM_ROUNDS));

   always_comb begin
      fsm_d = fsm_q;
      blk_d = blk_q;
      cnt_d = cnt_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               blk_d = in_message ^ key_q[NUM_ROUNDS];
               cnt_d = KA_W'(NUM_ROUNDS - 1);
               fsm_d = RUN;
            end
         end
         RUN: begin
            blk_d = round_out;
            if (cnt_q == '0) fsm_d = DONE;
            else             cnt_d = cnt_q - 1'b1;
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q <= IDLE;
         blk_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) key_q[i] <= '0;
      end else begin
         fsm_q <= fsm_d;
         blk_q <= blk_d;
         cnt_q <= cnt_d;
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (key_we && key_wr_addr == KA_W'(i)) key_q[i] <= key_wr_data;
         end
      end
   end

`ifdef DECRYPT_KEY_LOCK_EN
   logic key_err_q;

   assign key_we = key_wr_en && key_in_range && (fsm_q == IDLE);

   always_ff @(posedge clk) begin
      if (rst) key_err_q <= 1'b0;
      else     key_err_q <= key_wr_en && (fsm_q != IDLE);
   end

   assign key_wr_err = key_err_q;
`else
   assign key_we     = key_wr_en && key_in_range;
   assign key_wr_err = 1'b0;
`endif

   assign in_ready    = (fsm_q == IDLE);
   assign out_valid   = (fsm_q == DONE);
   assign out_message = out_valid ? blk_q : 16'h0000;

endmodule

// File: tb/tb_decrypt_iter.sv
// Directed and round-trip bench for decrypt_iter (NUM_ROUNDS=3, plus a NUM_ROUNDS=2 instance).
module tb_decrypt_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef DECRYPT_KEY_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_message, out_message;
   logic        key_wr_en, key_wr_err;
   logic [1:0]  key_wr_addr;
   logic [15:0] key_wr_data;

   logic        in_valid2, in_ready2, out_valid2, out_ready2;
   logic [15:0] in_message2, out_message2;
   logic        key_wr_en2, key_wr_err2;
   logic [1:0]  key_wr_addr2;
   logic [15:0] key_wr_data2;

   int tests = 0;
   int fails = 0;
   logic [63:0] keys;          // key i at keys[16*i +: 16]
   logic [3:0]  sbox_t [16];

   decrypt_iter #(.NUM_ROUNDS(3), .KA_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_message(in_message),
      .out_valid(out_valid), .out_ready(out_ready), .out_message(out_message),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
      .key_wr_err(key_wr_err)
   );

   decrypt_iter #(.NUM_ROUNDS(2), .KA_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_message(in_message2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_message(out_message2),
      .key_wr_en(key_wr_en2), .key_wr_addr(key_wr_addr2), .key_wr_data(key_wr_data2),
      .key_wr_err(key_wr_err2)
   );

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p, aa;
      p = 4'h0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p ^= aa;
         aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [3:0] inv_sub(input logic [3:0] x);
      for (int j = 0; j < 16; j++) if (sbox_t[j] == x) return j[3:0];
      return 4'h0;
   endfunction

   function automatic logic [15:0] dec_round(input logic [15:0] s, input logic [15:0] k);
      logic [3:0] n [4];
      logic [3:0] m [4];
      for (int i = 0; i < 4; i++) n[i] = s[15-4*i -: 4];
      m[0] = gmul(4'h9, n[0]) ^ gmul(4'h2, n[1]);
      m[1] = gmul(4'h2, n[0]) ^ gmul(4'h9, n[1]);
      m[2] = gmul(4'h9, n[2]) ^ gmul(4'h2, n[3]);
      m[3] = gmul(4'h2, n[2]) ^ gmul(4'h9, n[3]);
      return {inv_sub(m[0]), inv_sub(m[3]), inv_sub(m[2]), inv_sub(m[1])} ^ k;
   endfunction

   function automatic logic [15:0] enc_round(input logic [15:0] s, input logic [15:0] k);
      logic [15:0] t;
      logic [3:0]  u [4];
      t = s ^ k;
      u[0] = sbox_t[t[15:12]];
      u[1] = sbox_t[t[3:0]];
      u[2] = sbox_t[t[7:4]];
      u[3] = sbox_t[t[11:8]];
      return {u[0] ^ gmul(4'h4, u[1]), gmul(4'h4, u[0]) ^ u[1],
              u[2] ^ gmul(4'h4, u[3]), gmul(4'h4, u[2]) ^ u[3]};
   endfunction

   function automatic logic [15:0] dec_model(input logic [15:0] ct, input int n,
                                              input logic [63:0] k);
      logic [15:0] s;
      s = ct ^ k[16*n +: 16];
      for (int r = n - 1; r >= 0; r--) s = dec_round(s, k[16*r +: 16]);
      return s;
   endfunction

   function automatic logic [15:0] enc_model(input logic [15:0] pt, input int n,
                                              input logic [63:0] k);
      logic [15:0] s;
      s = pt;
      for (int r = 0; r < n; r++) s = enc_round(s, k[16*r +: 16]);
      return s ^ k[16*n +: 16];
   endfunction

   task automatic write_key(input logic [1:0] addr, input logic [15:0] data);
      key_wr_en = 1'b1;
      key_wr_addr = addr;
      key_wr_data = data;
      @(posedge clk); #1;
      key_wr_en = 1'b0;
   endtask

   task automatic load_std_keys();
      write_key(2'd0, 16'h1234);
      write_key(2'd1, 16'hABCD);
      write_key(2'd2, 16'h0F0F);
      write_key(2'd3, 16'hFFFF);
      keys = {16'hFFFF, 16'h0F0F, 16'hABCD, 16'h1234};
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Entered #1 after an edge; returns #1 after the output handshake edge.
   task automatic send(input logic [15:0] m, output logic [15:0] res, output int lat);
      int n;
      n = 0;
      in_message = m;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_message = 16'h0;
      wait_out(lat);
      res = out_message;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      keys = '0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (out_message !== 16'h0) begin fails++; $display("FAIL reset_out_msg got %h exp 0000", out_message); end
      tests++; if (key_wr_err !== 1'b0) begin fails++; $display("FAIL reset_key_err got %b exp 0", key_wr_err); end
   endtask

   task automatic test_zero_keys();
      logic [15:0] res;
      int lat;
      repeat (8) @(posedge clk);
      #1;
      send(16'h0000, res, lat);
      tests++; if (lat !== 3) begin fails++; $display("FAIL zero_latency got %0d exp 3", lat); end
      tests++; if (res !== 16'hCCCC) begin fails++; $display("FAIL zero_keys_out got %h exp cccc", res); end
      tests++; if (out_message !== 16'h0) begin fails++; $display("FAIL idle_out_msg got %h exp 0000", out_message); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_hs_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_hold();
      logic [15:0] exp;
      int lat, bad_msg, bad_rdy, bad_vld;
      load_std_keys();
      exp = dec_model(16'h5A3C, 3, keys);
      in_message = 16'h5A3C;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat);
      bad_msg = 0; bad_rdy = 0; bad_vld = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         in_message = 16'($urandom);
         @(posedge clk); #1;
         if (out_message !== exp) bad_msg++;
         if (in_ready !== 1'b0) bad_rdy++;
         if (out_valid !== 1'b1) bad_vld++;
      end
      tests++; if (bad_msg !== 0) begin fails++; $display("FAIL hold_msg got %0d bad cycles exp 0", bad_msg); end
      tests++; if (bad_rdy !== 0) begin fails++; $display("FAIL hold_in_ready got %0d bad cycles exp 0", bad_rdy); end
      tests++; if (bad_vld !== 0) begin fails++; $display("FAIL hold_out_valid got %0d bad cycles exp 0", bad_vld); end
      // in_valid held through the exit edge must not start a block
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL exit_no_accept got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL exit_out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      int accepts, outs, bad;
      exp = dec_model(16'h5A3C, 3, keys);
      accepts = 0; outs = 0; bad = 0;
      in_message = 16'h5A3C;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) accepts++;
         if (out_valid) begin
            outs++;
            if (out_message !== exp) bad++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++; if (accepts !== 4) begin fails++; $display("FAIL b2b_accepts got %0d exp 4", accepts); end
      tests++; if (outs !== 4) begin fails++; $display("FAIL b2b_outputs got %0d exp 4", outs); end
      tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_data got %0d bad exp 0", bad); end
   endtask

   task automatic test_key_write_run();
      logic [15:0] exp;
      logic [63:0] knew;
      int lat;
      knew = keys;
      knew[31:16] = 16'h5555;
      exp = dec_model(16'h0123, 3, LOCK ? keys : knew);
      in_message = 16'h0123;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      key_wr_en = 1'b1; key_wr_addr = 2'd1; key_wr_data = 16'h5555;
      @(posedge clk); #1;
      key_wr_en = 1'b0;
      tests++; if (key_wr_err !== LOCK) begin fails++; $display("FAIL run_wr_err got %b exp %b", key_wr_err, LOCK); end
      @(posedge clk); #1;
      tests++; if (key_wr_err !== 1'b0) begin fails++; $display("FAIL run_wr_err_pulse got %b exp 0", key_wr_err); end
      wait_out(lat);
      tests++; if (out_message !== exp) begin fails++; $display("FAIL run_wr_out got %h exp %h", out_message, exp); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (!LOCK) keys = knew;
   endtask

   task automatic test_read_old();
      logic [15:0] exp;
      int lat;
      exp = dec_model(16'h4567, 3, keys);
      in_message = 16'h4567;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // key 2 is consumed on the same edge that writes it
      key_wr_en = 1'b1; key_wr_addr = 2'd2; key_wr_data = 16'h9999;
      @(posedge clk); #1;
      key_wr_en = 1'b0;
      wait_out(lat);
      tests++; if (out_message !== exp) begin fails++; $display("FAIL read_old got %h exp %h", out_message, exp); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] res;
      int lat, seen;
      load_std_keys();
      in_message = 16'hBEEF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      key_wr_en = 1'b1; key_wr_addr = 2'd0; key_wr_data = 16'hFFFF;
      @(posedge clk); #1;
      rst = 1'b0;
      key_wr_en = 1'b0;
      keys = '0;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstrun_in_ready got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstrun_out_valid got %b exp 0", out_valid); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL rstrun_stale_out got %0d exp 0", seen); end
      send(16'h0000, res, lat);
      tests++; if (res !== 16'hCCCC) begin fails++; $display("FAIL rstrun_keys_zero got %h exp cccc", res); end
   endtask

   task automatic test_bad_addr();
      logic [15:0] exp;
      int lat;
      key_wr_en2 = 1'b1; key_wr_addr2 = 2'd2; key_wr_data2 = 16'h1234;
      @(posedge clk); #1;
      key_wr_addr2 = 2'd3; key_wr_data2 = 16'hFFFF;
      @(posedge clk); #1;
      key_wr_en2 = 1'b0;
      tests++; if (key_wr_err2 !== 1'b0) begin fails++; $display("FAIL bad_addr_err got %b exp 0", key_wr_err2); end
      exp = dec_model(16'h0000, 2, {16'h0000, 16'h1234, 16'h0000, 16'h0000});
      in_message2 = 16'h0000;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++; if (lat !== 2) begin fails++; $display("FAIL n2_latency got %0d exp 2", lat); end
      tests++; if (out_message2 !== exp) begin fails++; $display("FAIL bad_addr_out got %h exp %h", out_message2, exp); end
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] pt, ct, res, exp;
      int lat, bad_model, bad_trip;
      load_std_keys();
      bad_model = 0; bad_trip = 0;
      for (int i = 0; i < 1000; i++) begin
         pt = 16'($urandom);
         ct = enc_model(pt, 3, keys);
         exp = dec_model(ct, 3, keys);
         send(ct, res, lat);
         if (res !== exp) begin
            bad_model++;
            if (bad_model < 4) $display("FAIL rand_model ct %h got %h exp %h", ct, res, exp);
         end
         if (res !== pt) begin
            bad_trip++;
            if (bad_trip < 4) $display("FAIL rand_roundtrip ct %h got %h exp %h", ct, res, pt);
         end
      end
      tests++; if (bad_model !== 0) begin fails++; $display("FAIL rand_model_total got %0d exp 0", bad_model); end
      tests++; if (bad_trip !== 0) begin fails++; $display("FAIL rand_trip_total got %0d exp 0", bad_trip); end
   endtask

   initial begin
      sbox_t = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                 4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
      rst = 1'b1;
      in_valid = 1'b0; in_message = 16'h0; out_ready = 1'b0;
      key_wr_en = 1'b0; key_wr_addr = 2'd0; key_wr_data = 16'h0;
      in_valid2 = 1'b0; in_message2 = 16'h0; out_ready2 = 1'b0;
      key_wr_en2 = 1'b0; key_wr_addr2 = 2'd0; key_wr_data2 = 16'h0;
      keys = '0;
      test_reset();
      test_zero_keys();
      test_hold();
      test_back_to_back();
      test_key_write_run();
      test_read_old();
      test_reset_mid_run();
      test_bad_addr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
